exp_sequencer: RTL and testbench

- Upstream feeder and result collector for the exponential engine (start/done, 16-bit x in, 2-bit integer plus 16-bit fraction out).
- Buffers incoming x operands in a small FIFO and issues them to the engine one at a time using the engine's start/done protocol.
- Captures each 18-bit result and presents it on a valid/ready output stream, in order.

---
 rtl/exp_sequencer_if.sv | 32 +++
 rtl/exp_sequencer.sv | 173 +++++++++++++++++
 tb/tb_exp_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_sequencer_if.sv
// Bundles the operand, engine and result signals of exp_sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding system's view.
interface exp_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [15:0]       in_x;
  logic              in_ready;
  logic              exp_start;
  logic [15:0]       exp_x;
  logic              exp_done;
  logic [1:0]        exp_int;
  logic [15:0]       exp_frac;
  logic              out_valid;
  logic [17:0]       out_data;
  logic              out_ready;
  logic              busy;
  logic [FILL_W-1:0] fill;
  logic              out_err;

  modport master (
    input  in_valid, in_x, exp_done, exp_int, exp_frac, out_ready,
    output in_ready, exp_start, exp_x, out_valid, out_data, busy, fill, out_err
  );

  modport slave (
    output in_valid, in_x, exp_done, exp_int, exp_frac, out_ready,
    input  in_ready, exp_start, exp_x, out_valid, out_data, busy, fill, out_err
  );
endinterface

// File: rtl/exp_sequencer.sv
// Operand FIFO, start/done issue FSM and in-order result stream for the exponential engine.
// Optional watchdog: define EXP_SEQ_TIMEOUT_EN to abort a stuck operation after TIMEOUT cycles.
module exp_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  exp_sequencer_if.master  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535)
  begin : g_bad_params
    $error("exp_sequencer: DEPTH must be a power of two in 2..16 and TIMEOUT in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE, ISSUE, HOLD, WAIT_BUSY, WAIT_DONE, CAPTURE, OUT
  } state_t;

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill_q;
  logic              push;
  logic              pop;

  logic              start_q;
  logic [15:0]       x_q;
  logic              valid_q;
  logic [17:0]       data_q;
  logic              busy_q;

`ifdef EXP_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 255) ? 16 : 8;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  logic [WD_W-1:0]   wd_cnt;
  logic              timed_out;
  logic              err_q;
`endif

  // in_ready depends only on registered occupancy, so a full FIFO never accepts
  // in the same cycle it is popped.
  assign bus.in_ready = (fill_q != FILL_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == ISSUE);

  // NOTE: the storage array is deliberately not reset; pointers and fill alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_x;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      x_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
`ifdef EXP_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
      timed_out <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fill_q != '0 && bus.exp_done) begin
            state   <= ISSUE;
            start_q <= 1'b1;
            x_q     <= mem[rd_ptr];
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state   <= HOLD;
          start_q <= 1'b0;
        end
        // The engine loads x on the edge where it sees start low, so x_q stays put here.
        HOLD: begin
          state <= WAIT_BUSY;
`ifdef EXP_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (!bus.exp_done) state <= WAIT_DONE;
`ifdef EXP_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_LIMIT) begin
            state     <= CAPTURE;
            timed_out <= 1'b1;
          end
          wd_cnt <= wd_cnt + WD_W'(1);
`endif
        end
        WAIT_DONE: begin
          if (bus.exp_done) state <= CAPTURE;
`ifdef EXP_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_LIMIT) begin
            state     <= CAPTURE;
            timed_out <= 1'b1;
          end
          wd_cnt <= wd_cnt + WD_W'(1);
`endif
        end
        CAPTURE: begin
          state   <= OUT;
          valid_q <= 1'b1;
`ifdef EXP_SEQ_TIMEOUT_EN
          data_q    <= timed_out ? 18'h3FFFF : {bus.exp_int, bus.exp_frac};
          err_q     <= timed_out;
          timed_out <= 1'b0;
`else
          data_q  <= {bus.exp_int, bus.exp_frac};
`endif
        end
        OUT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (fill_q != '0) begin
              state   <= ISSUE;
              start_q <= 1'b1;
              x_q     <= mem[rd_ptr];
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          start_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.exp_start = start_q;
  assign bus.exp_x     = x_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;
  assign bus.fill      = fill_q;
`ifdef EXP_SEQ_TIMEOUT_EN
  assign bus.out_err   = err_q;
`else
  assign bus.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_exp_sequencer.sv
// Self-checking bench for exp_sequencer: engine stub, queue-based scoreboard,
// directed scenarios followed by a randomized traffic phase.
module tb_exp_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  exp_sequencer_if #(.DEPTH(DEPTH)) bus ();
  exp_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- engine stub ----------------
  int   stub_mode     = 0;
  int   stub_lat      = 3;
  bit   stub_rand_lat = 1'b0;
  bit   force_busy    = 1'b0;
  logic done_r;
  logic [17:0] res_r;
  logic [15:0] stub_x;
  int   stub_cnt;
  int   stub_phase;

  function automatic logic [17:0] engine_fn(input int mode, input logic [15:0] x);
    case (mode)
      0:       return {2'b00, x};
      1:       return {2'b01, 16'hA612};
      default: return {x[0], x[15], x ^ 16'h5A3C};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r     <= 1'b1;
      res_r      <= '0;
      stub_x     <= '0;
      stub_cnt   <= 0;
      stub_phase <= 0;
    end else begin
      case (stub_phase)
        0: if (bus.exp_start) stub_phase <= 1;
        1: if (!bus.exp_start) begin
             stub_x     <= bus.exp_x;
             done_r     <= 1'b0;
             stub_cnt   <= stub_rand_lat ? int'($urandom_range(0, 6)) : stub_lat;
             stub_phase <= 2;
           end
        default: begin
          if (stub_cnt == 0) begin
            done_r     <= 1'b1;
            res_r      <= engine_fn(stub_mode, stub_x);
            stub_phase <= 0;
          end else begin
            stub_cnt <= stub_cnt - 1;
          end
        end
      endcase
    end
  end

  assign bus.exp_done = done_r & ~force_busy;
  assign bus.exp_int  = res_r[17:16];
  assign bus.exp_frac = res_r[15:0];

  // ---------------- scoreboard / monitor (samples on falling edge) ----------------
  logic [15:0] push_q [$];
  logic [17:0] res_q  [$];
  int   n_pushed = 0;
  int   n_starts = 0;
  int   n_out    = 0;
  bit   prev_start, hold_chk, start_next, prev_stall;
  logic [15:0] hold_x;
  logic [17:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      push_q.delete();
      res_q.delete();
      prev_start = 1'b0;
      hold_chk   = 1'b0;
      start_next = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("fill", 32'(bus.fill), push_q.size());
      check("in_ready", 32'(bus.in_ready), 32'(push_q.size() != DEPTH));
      check("out_err", 32'(bus.out_err), 0);
      if (start_next) check("b2b_start", 32'(bus.exp_start), 1);
      start_next = 1'b0;
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.exp_start) begin
        check("start_pulse", 32'(prev_start), 0);
        check("start_while_out", 32'(bus.out_valid), 0);
        check("issue_nonempty", 32'(push_q.size() != 0), 1);
        if (push_q.size() != 0) begin
          check("exp_x_issue", 32'(bus.exp_x), 32'(push_q[0]));
          hold_x = push_q.pop_front();
          res_q.push_back(engine_fn(stub_mode, hold_x));
        end
        hold_chk = 1'b1;
        n_starts++;
      end else if (hold_chk) begin
        check("exp_x_hold", 32'(bus.exp_x), 32'(hold_x));
        hold_chk = 1'b0;
      end
      prev_start = bus.exp_start;
      if (bus.in_valid && bus.in_ready) begin
        push_q.push_back(bus.in_x);
        n_pushed++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("out_nonempty", 32'(res_q.size() != 0), 1);
        if (res_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(res_q.pop_front()));
        n_out++;
        start_next = (bus.fill != '0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x);
    bit ok;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      n++;
    end while (!ok && n < 200);
    bus.in_valid = 1'b0;
    check("push_accept", 32'(ok), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 1);
    check({tag, "_exp_start"}, 32'(bus.exp_start), 0);
    check({tag, "_exp_x"},     32'(bus.exp_x), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},  32'(bus.out_data), 0);
    check({tag, "_busy"},      32'(bus.busy), 0);
    check({tag, "_fill"},      32'(bus.fill), 0);
    check({tag, "_out_err"},   32'(bus.out_err), 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((push_q.size() != 0 || res_q.size() != 0 || bus.out_valid || bus.busy) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int s0, o0, n, target;
    logic [15:0] x5;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    step();
    check_reset("post_rst");

    // Single operand, then 10 cycles of backpressure
    stub_mode = 1;
    stub_lat  = 20;
    s0 = n_starts;
    push(16'h8000);
    n = 0;
    while (!bus.out_valid && n < 200) begin step(); n++; end
    check("single_valid", 32'(bus.out_valid), 1);
    check("single_data", 32'(bus.out_data), 32'h1A612);
    check("single_busy", 32'(bus.busy), 1);
    check("single_starts", n_starts - s0, 1);
    repeat (10) begin
      step();
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_data", 32'(bus.out_data), 32'h1A612);
    end
    check("bp_no_start", n_starts - s0, 1);
    bus.out_ready = 1'b1;
    step();
    check("acc_valid_low", 32'(bus.out_valid), 0);
    check("acc_data_held", 32'(bus.out_data), 32'h1A612);
    wait_drain("single", 100);

    // Back-to-back with an echoing engine
    stub_mode = 0;
    stub_lat  = 2;
    o0 = n_out;
    push(16'h0000);
    push(16'h4000);
    push(16'hFFFF);
    wait_drain("b2b", 300);
    check("b2b_count", n_out - o0, 3);

    // Full FIFO while the engine reports busy
    stub_mode  = 2;
    force_busy = 1'b1;
    o0 = n_out;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    check("full_fill", 32'(bus.fill), 4);
    check("full_in_ready", 32'(bus.in_ready), 0);
    x5 = 16'($urandom);
    bus.in_valid = 1'b1;
    bus.in_x     = x5;
    repeat (3) step();
    check("full_blocked_fill", 32'(bus.fill), 4);
    check("full_no_start", n_starts - s0, 0);
    force_busy = 1'b0;
    push(x5);
    check("full_refill", 32'(bus.fill), 4);
    check("full_refill_ready", 32'(bus.in_ready), 0);
    wait_drain("full", 500);
    check("full_count", n_out - o0, 5);

    // Reset in the middle of WAIT_DONE with two operands queued
    stub_mode = 0;
    stub_lat  = 40;
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    n = 0;
    while (bus.exp_done && n < 50) begin step(); n++; end
    step();
    check("rst_setup_busy", 32'(bus.exp_done), 0);
    check("rst_setup_fill", 32'(bus.fill), 2);
    rst = 1'b1;
    step();
    check_reset("mid_rst");
    rst = 1'b0;
    s0 = n_starts;
    repeat (20) step();
    check("rst_no_start", n_starts - s0, 0);
    check_reset("idle_after_rst");
    stub_lat = 3;
    o0 = n_out;
    push(16'h1234);
    wait_drain("after_rst", 200);
    check("after_rst_count", n_out - o0, 1);

    // Randomized traffic with random engine latency and backpressure
    stub_mode     = 2;
    stub_rand_lat = 1'b1;
    o0     = n_out;
    s0     = n_pushed;
    target = n_pushed + 150;
    n = 0;
    while (n_pushed < target && n < 20000) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_x      = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    wait_drain("random", 3000);
    check("random_count", n_out - o0, n_pushed - s0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
